// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access sequencer and its wait timer.
package mem_ctrl_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // Beat selector bit, appended as the LSB of the half-word address.
  localparam logic BEAT_LO = 1'b0;
  localparam logic BEAT_HI = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT_LO,
    S_BEAT_HI,
    S_RESP
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Per-beat wait counter for the access sequencer; only built when MEM_TIMEOUT_EN is defined.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Counter saturates at the expiry value so the flag stays up until the next clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_sequencer.sv
// Splits one 32-bit core load/store into two 16-bit memory beats (low half first).
// Optional per-beat abort on missing ack is enabled by defining MEM_TIMEOUT_EN.
module mem_access_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-2:0]   req_addr,
  input  logic [WORD_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [WORD_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                marce,
  output logic                mdrce,
  output logic                mdroe,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [HALF_W-1:0]   mem_wdata,
  input  logic [HALF_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  state_t              state, state_nx;
  logic [ADDR_W-2:0]   mar;
  logic                wr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                err_q;
  logic                accept;
  logic                in_beat;
  logic                beat;
  logic                timeout_hit;

  assign accept  = (state == S_IDLE) && req_valid;
  assign in_beat = (state == S_BEAT_LO) || (state == S_BEAT_HI);
  assign beat    = (state == S_BEAT_HI) ? BEAT_HI : BEAT_LO;

`ifdef MEM_TIMEOUT_EN
  logic wait_expired;
  logic beat_entry;

  // Counter restarts whenever a fresh beat begins: on accept and on the low-beat ack.
  assign beat_entry = accept || ((state == S_BEAT_LO) && mem_ack);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (beat_entry),
    .run     (in_beat && !mem_ack),
    .expired (wait_expired)
  );

  assign timeout_hit = in_beat && !mem_ack && wait_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (req_valid) state_nx = S_BEAT_LO;
      S_BEAT_LO: if (mem_ack) state_nx = S_BEAT_HI;
                 else if (timeout_hit) state_nx = S_RESP;
      S_BEAT_HI: if (mem_ack || timeout_hit) state_nx = S_RESP;
      S_RESP:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Request latch plus read assembly; an abort wipes partial load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      mar     <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        mar     <= req_addr;
        wr_q    <= req_write;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (timeout_hit) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else if (in_beat && mem_ack && !wr_q) begin
        if (beat == BEAT_HI) rdata_q[WORD_W-1:HALF_W] <= mem_rdata;
        else                 rdata_q[HALF_W-1:0]      <= mem_rdata;
      end
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    marce      = 1'b0;
    mdrce      = 1'b0;
    mdroe      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        marce     = req_valid;
      end
      S_BEAT_LO, S_BEAT_HI: begin
        mem_read  = !wr_q;
        mdrce     = !wr_q;
        mem_write = wr_q;
        mdroe     = wr_q;
        mem_addr  = {mar, beat};
        if (wr_q) begin
          mem_wdata = (beat == BEAT_HI) ? wdata_q[WORD_W-1:HALF_W] : wdata_q[HALF_W-1:0];
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer; timeout checks follow MEM_TIMEOUT_EN.
module tb_mem_access_sequencer;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-2:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              marce, mdrce, mdroe, mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata = '0;
  logic              mem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .marce(marce), .mdrce(mdrce), .mdroe(mdroe),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    int          len;
  } beat_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  resp_t exp_q[$];
  resp_t got_q[$];
  beat_t beat_q[$];
  int    acc_q[$];
  int    marce_cnt = 0;
  int    both_cnt = 0;
  int    ready_busy_cnt = 0;
  int    run_len = 0;

  logic [15:0] mem16 [logic [15:0]];
  int wait_lo = 0;
  int wait_hi = 0;
  bit ack_en = 1'b1;
  int wcnt = 0;

  always @(posedge clk) cyc++;

  // Memory model: acks each beat after a configurable number of wait cycles.
  always @(posedge clk) begin
    #1;
    if (rst || !ack_en || !(mem_read || mem_write)) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else begin
      if (mem_ack) wcnt = 0;
      if (wcnt >= (mem_addr[0] ? wait_hi : wait_lo)) begin
        mem_ack = 1'b1;
        mem_rdata = mem16.exists(mem_addr) ? mem16[mem_addr] : 16'h0000;
        if (mem_write) mem16[mem_addr] = mem_wdata;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Monitor: logs accepts, beats and responses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read && mem_write) both_cnt++;
      if ((mem_read || mem_write) && req_ready) ready_busy_cnt++;
      if (marce) marce_cnt++;
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (mem_read || mem_write) begin
        run_len++;
        if (mem_ack) begin
          beat_q.push_back('{addr: mem_addr, wr: mem_write, wdata: mem_wdata, len: run_len});
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
      if (resp_valid) got_q.push_back('{rdata: resp_rdata, err: resp_err, cyc: cyc});
    end else begin
      run_len = 0;
    end
  end

  task automatic clear_logs();
    exp_q.delete();
    got_q.delete();
    beat_q.delete();
    acc_q.delete();
    marce_cnt = 0;
    ready_busy_cnt = 0;
  endtask

  task automatic issue(input logic wr, input logic [ADDR_W-2:0] addr, input logic [31:0] wd);
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready); end
    n_cmp++; if ({marce, mdrce, mdroe, mem_read, mem_write, resp_valid, resp_err} !== 7'b0) begin
      n_fail++; $display("[TB] FAIL reset_strobes got=%b exp=0", {marce, mdrce, mdroe, mem_read, mem_write, resp_valid, resp_err}); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata got=%h exp=0", resp_rdata); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_load_immediate();
    bit ok;
    resp_t g, e;
    clear_logs();
    wait_lo = 0; wait_hi = 0;
    mem16[16'h0024] = 16'hBEEF;
    mem16[16'h0025] = 16'hDEAD;
    exp_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, cyc: 3});
    issue(1'b0, 15'h0012, 32'h0);
    wait_resp(1, 20, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL load_resp_seen got=none exp=response"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g.rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL load_rdata got=%h exp=%h", g.rdata, e.rdata); end
      n_cmp++; if (g.err !== e.err) begin n_fail++; $display("[TB] FAIL load_err got=%b exp=%b", g.err, e.err); end
      n_cmp++; if (g.cyc - acc_q[0] !== e.cyc) begin n_fail++; $display("[TB] FAIL load_latency got=%0d exp=%0d", g.cyc - acc_q[0], e.cyc); end
    end
    n_cmp++; if (beat_q.size() !== 2) begin n_fail++; $display("[TB] FAIL load_beats got=%0d exp=2", beat_q.size()); end
    else begin
      n_cmp++; if (beat_q[0].addr !== 16'h0024 || beat_q[0].wr !== 1'b0) begin
        n_fail++; $display("[TB] FAIL load_beat_lo got=%h/%b exp=0024/0", beat_q[0].addr, beat_q[0].wr); end
      n_cmp++; if (beat_q[1].addr !== 16'h0025 || beat_q[1].wr !== 1'b0) begin
        n_fail++; $display("[TB] FAIL load_beat_hi got=%h/%b exp=0025/0", beat_q[1].addr, beat_q[1].wr); end
    end
  endtask

  task automatic test_store_waits();
    bit ok;
    resp_t g, e;
    clear_logs();
    wait_lo = 2; wait_hi = 2;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, cyc: 7});
    issue(1'b1, 15'h0100, 32'hCAFE1234);
    wait_resp(1, 30, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL store_resp_seen got=none exp=response"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g.rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL store_rdata got=%h exp=%h", g.rdata, e.rdata); end
      n_cmp++; if (g.cyc - acc_q[0] !== e.cyc) begin n_fail++; $display("[TB] FAIL store_latency got=%0d exp=%0d", g.cyc - acc_q[0], e.cyc); end
    end
    n_cmp++; if (beat_q.size() !== 2) begin n_fail++; $display("[TB] FAIL store_beats got=%0d exp=2", beat_q.size()); end
    else begin
      n_cmp++; if (beat_q[0].wdata !== 16'h1234 || beat_q[0].len !== 3 || beat_q[0].addr !== 16'h0200 || beat_q[0].wr !== 1'b1) begin
        n_fail++; $display("[TB] FAIL store_beat_lo got=%h/%0d/%h exp=1234/3/0200", beat_q[0].wdata, beat_q[0].len, beat_q[0].addr); end
      n_cmp++; if (beat_q[1].wdata !== 16'hCAFE || beat_q[1].len !== 3 || beat_q[1].addr !== 16'h0201 || beat_q[1].wr !== 1'b1) begin
        n_fail++; $display("[TB] FAIL store_beat_hi got=%h/%0d/%h exp=CAFE/3/0201", beat_q[1].wdata, beat_q[1].len, beat_q[1].addr); end
    end
    wait_lo = 0; wait_hi = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    resp_t g, e;
    clear_logs();
    mem16[16'h0030] = 16'h1111; mem16[16'h0031] = 16'h2222;
    mem16[16'h0032] = 16'h3333; mem16[16'h0033] = 16'h4444;
    exp_q.push_back('{rdata: 32'h22221111, err: 1'b0, cyc: 3});
    exp_q.push_back('{rdata: 32'h44443333, err: 1'b0, cyc: 3});
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0018;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (acc_q.size() >= 1) break;
    end
    @(posedge clk); #2;
    req_addr = 15'h0019;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (acc_q.size() >= 2) break;
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    wait_resp(2, 30, ok);
    n_cmp++; if (!ok || acc_q.size() != 2) begin n_fail++; $display("[TB] FAIL b2b_resp_seen got=%0d/%0d exp=2/2", got_q.size(), acc_q.size()); end
    else begin
      n_cmp++; if (acc_q[1] !== got_q[0].cyc + 1) begin
        n_fail++; $display("[TB] FAIL b2b_second_accept got=%0d exp=%0d", acc_q[1], got_q[0].cyc + 1); end
      for (int k = 0; k < 2; k++) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        n_cmp++; if (g.rdata !== e.rdata || g.cyc - acc_q[k] !== e.cyc) begin
          n_fail++; $display("[TB] FAIL b2b_resp%0d got=%h@%0d exp=%h@%0d", k, g.rdata, g.cyc - acc_q[k], e.rdata, e.cyc); end
      end
    end
    n_cmp++; if (marce_cnt !== 2) begin n_fail++; $display("[TB] FAIL b2b_marce got=%0d exp=2", marce_cnt); end
    n_cmp++; if (ready_busy_cnt !== 0) begin n_fail++; $display("[TB] FAIL b2b_ready_busy got=%0d exp=0", ready_busy_cnt); end
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    clear_logs();
    wait_lo = 0; wait_hi = 1000;
    issue(1'b0, 15'h0040, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_read && mem_addr == 16'h0081) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_fail++; $display("[TB] FAIL rst_mid_reach_hi got=no exp=beat_hi"); end
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({req_ready, mem_read, mem_write, mdrce, mdroe, resp_valid} !== 6'b100000) begin
      n_fail++; $display("[TB] FAIL rst_mid_state got=%b exp=100000", {req_ready, mem_read, mem_write, mdrce, mdroe, resp_valid}); end
    @(posedge clk); #2;
    rst = 1'b0;
    wait_hi = 0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (got_q.size() !== 0) begin n_fail++; $display("[TB] FAIL rst_mid_no_resp got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_timeout();
    clear_logs();
    ack_en = 1'b0;
    issue(1'b0, 15'h0050, 32'h0);
`ifdef MEM_TIMEOUT_EN
    begin
      bit ok;
      resp_t g;
      wait_resp(1, 40, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL timeout_resp_seen got=none exp=response"); end
      else begin
        g = got_q.pop_front();
        n_cmp++; if (g.err !== 1'b1 || g.rdata !== 32'h0) begin
          n_fail++; $display("[TB] FAIL timeout_resp got=%b/%h exp=1/00000000", g.err, g.rdata); end
      end
      @(negedge clk);
      n_cmp++; if ({mem_read, mem_write, mdrce, mdroe} !== 4'b0) begin
        n_fail++; $display("[TB] FAIL timeout_strobes got=%b exp=0000", {mem_read, mem_write, mdrce, mdroe}); end
    end
`else
    repeat (40) @(negedge clk);
    #1;
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 16'h00A0 || req_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stall_beat_lo got=%b/%h/%b exp=1/00a0/0", mem_read, mem_addr, req_ready); end
    n_cmp++; if (got_q.size() !== 0) begin n_fail++; $display("[TB] FAIL stall_no_resp got=%0d exp=0", got_q.size()); end
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
`endif
    ack_en = 1'b1;
  endtask

  task automatic test_addr_wrap();
    bit ok;
    resp_t g, e;
    clear_logs();
    mem16[16'hFFFE] = 16'h5A5A;
    mem16[16'hFFFF] = 16'hA5A5;
    exp_q.push_back('{rdata: 32'hA5A55A5A, err: 1'b0, cyc: 3});
    issue(1'b0, 15'h7FFF, 32'h0);
    wait_resp(1, 20, ok);
    n_cmp++; if (!ok || beat_q.size() != 2) begin n_fail++; $display("[TB] FAIL wrap_seen got=%0d/%0d exp=1/2", got_q.size(), beat_q.size()); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (beat_q[0].addr !== 16'hFFFE || beat_q[1].addr !== 16'hFFFF) begin
        n_fail++; $display("[TB] FAIL wrap_addr got=%h/%h exp=fffe/ffff", beat_q[0].addr, beat_q[1].addr); end
      n_cmp++; if (g.rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL wrap_rdata got=%h exp=%h", g.rdata, e.rdata); end
    end
  endtask

  initial begin
    $display("[TB] starting mem_access_sequencer bench");
    test_reset();
    test_load_immediate();
    test_store_waits();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    test_addr_wrap();
    n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("[TB] FAIL read_write_exclusive got=%0d exp=0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
